lsu_mem_initiator: RTL and testbench

Load/store initiator that sits between the pipeline's memory stage and the byte-addressed, little-endian data `memory` block. It accepts one byte, halfword or word request at a time over a valid/ready handshake and drives the memory's `addr/data/read_en/write_en` port. Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended, and the result is returned over a valid/ready response channel.

---
 rtl/lsu_mem_initiator.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the memory stage and the byte-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses as errors.
module lsu_mem_initiator #(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter int unsigned       MEM_DEPTH = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_OFS = AWIDTH'(MEM_DEPTH - 4);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rd_q;
    logic [DWIDTH-1:0] rdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              err_q;

    logic [AWIDTH-1:0] ofs;
    logic              misalign;
    logic              req_err;
    logic              accept;
    logic [DWIDTH-1:0] merged;

    assign ofs = req_addr_i - BASE_ADDR;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (req_addr_i < BASE_ADDR) || (ofs > LAST_OFS) ||
                     (req_size_i == 2'b11) || misalign;

    assign accept = (state_q == IDLE) && req_valid_i;

    function automatic logic [DWIDTH-1:0] extend(input logic [DWIDTH-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic uns);
        logic [DWIDTH-1:0] r;
        case (sz)
            2'b00:   r = uns ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   r = uns ? {16'h0000, d[15:0]}   : {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        case (size_q)
            2'b00:   merged = {rd_q[31:8], wdata_q[7:0]};
            2'b01:   merged = {rd_q[31:16], wdata_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst so the memory enables drop the moment reset rises.
    always_comb begin
        state_d        = state_q;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_rdata_o    = '0;
        rsp_err_o      = 1'b0;
        mem_addr_o     = BASE_ADDR;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        if (req_err)
                            state_d = RSP;
                        else if (req_we_i && (req_size_i == 2'b10))
                            state_d = WR;
                        else
                            state_d = RD;
                    end
                end
                RD: begin
                    mem_read_en_o = 1'b1;
                    mem_addr_o    = addr_q;
                    state_d       = we_q ? WR : RSP;
                end
                WR: begin
                    mem_write_en_o = 1'b1;
                    mem_addr_o     = addr_q;
                    mem_data_o     = merged;
                    state_d        = RSP;
                end
                RSP: begin
                    rsp_valid_o = 1'b1;
                    rsp_rdata_o = rdata_q;
                    rsp_err_o   = err_q;
                    if (rsp_ready_i)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                size_q  <= req_size_i;
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state_q == RD) begin
                rd_q <= mem_data_i;
                if (!we_q)
                    rdata_q <= extend(mem_data_i, size_q, uns_q);
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a small little-endian byte memory model.
module tb_lsu_mem_initiator;

    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int unsigned DEPTH = 1048576;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o;

    lsu_mem_initiator #(
        .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_read_en_o(mem_read_en_o),
        .mem_write_en_o(mem_write_en_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // 256-byte window of the memory; the low address byte selects the location.
    logic [7:0] mem [0:255] = '{default: 8'h00};
    logic [7:0] i0, i1, i2, i3;
    assign i0 = mem_addr_o[7:0];
    assign i1 = i0 + 8'd1;
    assign i2 = i0 + 8'd2;
    assign i3 = i0 + 8'd3;
    assign mem_data_i = {mem[i3], mem[i2], mem[i1], mem[i0]};

    always @(posedge clk) begin
        if (mem_write_en_o) begin
            mem[i0] <= mem_data_o[7:0];
            mem[i1] <= mem_data_o[15:8];
            mem[i2] <= mem_data_o[23:16];
            mem[i3] <= mem_data_o[31:24];
        end
    end

    int          n_rd = 0, n_wr = 0;
    logic [31:0] last_wdata = 32'h0;
    always @(negedge clk) begin
        if (mem_read_en_o) n_rd++;
        if (mem_write_en_o) begin
            n_wr++;
            last_wdata = mem_data_o;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          lat, drd, dwr, wr0;
    logic [31:0] rdv, hold;
    logic        errv;

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns);
        int rd0, w0;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
        rd0 = n_rd; w0 = n_wr;
        req_we_i = we; req_addr_i = addr; req_wdata_i = wd;
        req_size_i = sz; req_unsigned_i = uns; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdv = rsp_rdata_o; errv = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        drd = n_rd - rd0; dwr = n_wr - w0;
    endtask

    task automatic expect_rsp(input string tag, input int e_lat, input logic [31:0] e_data,
                              input logic e_err, input int e_rd, input int e_wr);
        chk({tag, ".lat"},   lat,  e_lat);
        chk({tag, ".rdata"}, rdv,  e_data);
        chk({tag, ".err"},   {31'b0, errv}, {31'b0, e_err});
        chk({tag, ".nrd"},   drd,  e_rd);
        chk({tag, ".nwr"},   dwr,  e_wr);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; req_size_i = 2'b00;
        rsp_ready_i = 1'b0;

        #12;
        chk("rst.req_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst.rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst.rsp_err",   {31'b0, rsp_err_o}, 32'd0);
        chk("rst.rdata",     rsp_rdata_o, 32'h0);
        chk("rst.rd_en",     {31'b0, mem_read_en_o}, 32'd0);
        chk("rst.wr_en",     {31'b0, mem_write_en_o}, 32'd0);
        chk("rst.mem_data",  mem_data_o, 32'h0);
        chk("rst.mem_addr",  mem_addr_o, BASE);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel.req_ready", {31'b0, req_ready_o}, 32'd1);

        do_req(1'b1, BASE + 4, 32'hDEADBEEF, 2'b10, 1'b0);
        expect_rsp("st_word", 2, 32'h0, 1'b0, 0, 1);
        do_req(1'b0, BASE + 4, 32'h0, 2'b10, 1'b0);
        expect_rsp("ld_word", 2, 32'hDEADBEEF, 1'b0, 1, 0);
        do_req(1'b0, BASE + 4, 32'h0, 2'b00, 1'b0);
        expect_rsp("ld_sbyte", 2, 32'hFFFFFFEF, 1'b0, 1, 0);
        do_req(1'b0, BASE + 7, 32'h0, 2'b00, 1'b1);
        expect_rsp("ld_ubyte", 2, 32'h000000DE, 1'b0, 1, 0);
        do_req(1'b0, BASE + 6, 32'h0, 2'b01, 1'b0);
        expect_rsp("ld_shalf", 2, 32'hFFFFDEAD, 1'b0, 1, 0);

        do_req(1'b1, BASE + 8, 32'h12345678, 2'b10, 1'b0);
        expect_rsp("st_word8", 2, 32'h0, 1'b0, 0, 1);
        do_req(1'b1, BASE + 5, 32'hAAAAAA55, 2'b00, 1'b0);
        expect_rsp("st_byte", 3, 32'h0, 1'b0, 1, 1);
        chk("st_byte.merged", last_wdata, 32'h78DEAD55);
        do_req(1'b0, BASE + 4, 32'h0, 2'b10, 1'b0);
        expect_rsp("ld_after_sb", 2, 32'hDEAD55EF, 1'b0, 1, 0);
        do_req(1'b0, BASE + 4, 32'h0, 2'b01, 1'b1);
        expect_rsp("ld_uhalf", 2, 32'h000055EF, 1'b0, 1, 0);
        do_req(1'b0, BASE + 8, 32'h0, 2'b00, 1'b0);
        expect_rsp("ld_sbyte_pos", 2, 32'h00000078, 1'b0, 1, 0);

        do_req(1'b0, BASE + 5, 32'h0, 2'b01, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        expect_rsp("misalign_half", 1, 32'h0, 1'b1, 0, 0);
`else
        expect_rsp("misalign_half", 2, 32'hFFFFAD55, 1'b0, 1, 0);
`endif

        do_req(1'b0, 32'h00FFFFFC, 32'h0, 2'b10, 1'b0);
        expect_rsp("oor_low", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, BASE + DEPTH - 3, 32'h0, 2'b00, 1'b0);
        expect_rsp("oor_high", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b1, BASE + 4, 32'h11111111, 2'b11, 1'b0);
        expect_rsp("size_ill", 1, 32'h0, 1'b1, 0, 0);
        do_req(1'b0, BASE + DEPTH - 4, 32'h0, 2'b10, 1'b0);
        expect_rsp("last_legal", 2, 32'h0, 1'b0, 1, 0);

        // Backpressure: a second request stays pending while the response is held.
        @(negedge clk);
        req_we_i = 1'b0; req_addr_i = BASE + 4; req_size_i = 2'b10;
        req_unsigned_i = 1'b0; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_addr_i = BASE + 7; req_size_i = 2'b00; req_unsigned_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
            chk("bp.rdata",     rsp_rdata_o, 32'hDEAD55EF);
            chk("bp.req_ready", {31'b0, req_ready_o}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        chk("bp.after_hs_ready", {31'b0, req_ready_o}, 32'd1);
        chk("bp.after_hs_valid", {31'b0, rsp_valid_o}, 32'd0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp.pend_lat",   lat, 32'd2);
        chk("bp.pend_rdata", rsp_rdata_o, 32'h000000DE);
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;

        // Reset pulsed during the write cycle of a byte store.
        @(negedge clk);
        wr0 = n_wr;
        req_we_i = 1'b1; req_addr_i = BASE + 4; req_wdata_i = 32'h00000099;
        req_size_i = 2'b00; req_unsigned_i = 1'b0; req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rstwr.wr_en_before", {31'b0, mem_write_en_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr.wr_en",     {31'b0, mem_write_en_o}, 32'd0);
        chk("rstwr.rd_en",     {31'b0, mem_read_en_o}, 32'd0);
        chk("rstwr.req_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rstwr.mem_addr",  mem_addr_o, BASE);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwr.ready_rel", {31'b0, req_ready_o}, 32'd1);
        chk("rstwr.nwr",       n_wr - wr0, 32'd0);
        do_req(1'b0, BASE + 4, 32'h0, 2'b10, 1'b0);
        expect_rsp("rstwr.mem_kept", 2, 32'hDEAD55EF, 1'b0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
